// File: rtl/instruction_buffer_lvl3.sv
// Decode-to-execute instruction buffer: in-order circular FIFO with empty bypass,
// execute-lookahead pop, pipeline flush and an occupancy high-water mark.
module instruction_buffer_lvl3 #(
  parameter int WIDTH       = 32,
  parameter int DEPTH       = 4,
  parameter int LONG_BYPASS = 0,
  localparam int CW         = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             instr_in_valid,
  input  logic [WIDTH-1:0] instr_in_data,
  input  logic             instr_is_long,
  output logic             instr_in_stall,
  input  logic             exec_busy,
  input  logic             exec_will_free_next,
  output logic             instr_out_valid,
  output logic [WIDTH-1:0] instr_out_data,
  output logic             instr_out_is_long,
  output logic [CW-1:0]    count,
  output logic [CW-1:0]    high_water,
  output logic             empty,
  output logic             full
);

  // Handshake: decode holds instr_in_valid/data/is_long stable while
  // instr_in_stall is high; the instruction is taken in the first cycle it is
  // low. Dispatch is a one-cycle instr_out_valid pulse with no backpressure.

  localparam int            PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic          LB       = (LONG_BYPASS != 0);

  logic [WIDTH:0]  mem [DEPTH];
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [CW-1:0]   count_next;
  logic            issue;
  logic            pop;
  logic            bypass;
  logic            push;

  assign issue  = !exec_busy || exec_will_free_next;
  assign pop    = issue && (count != '0) && !flush;
  // Bypass only when empty keeps dispatch strictly in order.
  assign bypass = issue && (count == '0) && instr_in_valid
                  && (!instr_is_long || LB) && !flush;
  // A full buffer still accepts when an entry leaves on the same edge.
  assign push   = instr_in_valid && !bypass && !flush
                  && ((count < DEPTH_C) || pop);
  assign instr_in_stall = instr_in_valid && !flush && !bypass && !push;

  assign empty = (count == '0);
  assign full  = (count == DEPTH_C);

  always_comb begin
    count_next = count;
    if (flush)             count_next = '0;
    else if (push && !pop) count_next = count + CW'(1);
    else if (pop && !push) count_next = count - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {instr_is_long, instr_in_data};
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_ptr            <= '0;
      wr_ptr            <= '0;
      count             <= '0;
      high_water        <= '0;
      instr_out_valid   <= 1'b0;
      instr_out_data    <= '0;
      instr_out_is_long <= 1'b0;
    end else begin
      count <= count_next;
      // Flush leaves the mark alone: count_next is zero then.
      if (count_next > high_water) high_water <= count_next;
      if (flush) begin
        rd_ptr          <= '0;
        wr_ptr          <= '0;
        instr_out_valid <= 1'b0;
      end else begin
        if (push) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PW'(1);
        if (pop) begin
          rd_ptr            <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PW'(1);
          instr_out_valid   <= 1'b1;
          instr_out_data    <= mem[rd_ptr][WIDTH-1:0];
          instr_out_is_long <= mem[rd_ptr][WIDTH];
        end else if (bypass) begin
          instr_out_valid   <= 1'b1;
          instr_out_data    <= instr_in_data;
          instr_out_is_long <= instr_is_long;
        end else begin
          instr_out_valid   <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_instruction_buffer_lvl3.sv
// Bench for instruction_buffer_lvl3: directed scenarios plus randomized traffic
// checked against a queue-based reference model of the buffer.
module tb_instruction_buffer_lvl3;

  localparam int WIDTH = 32;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam bit LB    = 1'b0;

  logic             clk = 1'b0;
  logic             reset;
  logic             flush;
  logic             instr_in_valid;
  logic [WIDTH-1:0] instr_in_data;
  logic             instr_is_long;
  logic             instr_in_stall;
  logic             exec_busy;
  logic             exec_will_free_next;
  logic             instr_out_valid;
  logic [WIDTH-1:0] instr_out_data;
  logic             instr_out_is_long;
  logic [CW-1:0]    count;
  logic [CW-1:0]    high_water;
  logic             empty;
  logic             full;

  int checks   = 0;
  int failures = 0;

  // Reference model: queue of {is_long, data} entries plus dispatch register.
  logic [WIDTH:0]   exp_q[$];
  logic             m_valid;
  logic [WIDTH-1:0] m_data;
  logic             m_long;
  logic [CW-1:0]    m_hw;
  logic             exp_stall;
  logic             accepted;
  logic             obs_stall;

  instruction_buffer_lvl3 #(.WIDTH(WIDTH), .DEPTH(DEPTH), .LONG_BYPASS(0)) dut (
    .clk                 (clk),
    .reset               (reset),
    .flush               (flush),
    .instr_in_valid      (instr_in_valid),
    .instr_in_data       (instr_in_data),
    .instr_is_long       (instr_is_long),
    .instr_in_stall      (instr_in_stall),
    .exec_busy           (exec_busy),
    .exec_will_free_next (exec_will_free_next),
    .instr_out_valid     (instr_out_valid),
    .instr_out_data      (instr_out_data),
    .instr_out_is_long   (instr_out_is_long),
    .count               (count),
    .high_water          (high_water),
    .empty               (empty),
    .full                (full)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Model update for one clock edge, evaluated from the inputs held this cycle.
  task automatic model_edge();
    int  n;
    bit  can_issue, take_old, send_new, store_new;
    logic [WIDTH:0] e;
    n         = exp_q.size();
    can_issue = !exec_busy || exec_will_free_next;
    take_old  = can_issue && n > 0 && !flush;
    send_new  = can_issue && n == 0 && instr_in_valid && (!instr_is_long || LB) && !flush;
    store_new = instr_in_valid && !flush && !send_new && (n < DEPTH || take_old);
    exp_stall = instr_in_valid && !flush && !send_new && !store_new;
    accepted  = 1'b0;
    if (!reset) begin
      exp_q.delete();
      m_valid = 1'b0; m_data = '0; m_long = 1'b0; m_hw = '0;
    end else if (flush) begin
      exp_q.delete();
      m_valid = 1'b0;
    end else begin
      if (take_old) begin
        e = exp_q.pop_front();
        m_valid = 1'b1; m_data = e[WIDTH-1:0]; m_long = e[WIDTH];
      end else if (send_new) begin
        m_valid = 1'b1; m_data = instr_in_data; m_long = instr_is_long;
      end else begin
        m_valid = 1'b0;
      end
      if (store_new) exp_q.push_back({instr_is_long, instr_in_data});
      if (exp_q.size() > int'(m_hw)) m_hw = CW'(exp_q.size());
      accepted = send_new || store_new;
    end
  endtask

  // Driver: inputs are set just after a rising edge; stall is sampled at the
  // falling edge, registered outputs 1 time unit after the next rising edge.
  task automatic cycle();
    @(negedge clk);
    obs_stall = instr_in_stall;
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [WIDTH-1:0] d, input logic lg,
                       input logic busy, input logic fn, input logic fl);
    instr_in_valid = v; instr_in_data = d; instr_is_long = lg;
    exec_busy = busy; exec_will_free_next = fn; flush = fl;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle();
    cycle();
    checks++;
    if ({instr_out_valid, instr_out_data, instr_out_is_long, count, high_water, empty, full}
        !== {1'b0, 32'h0, 1'b0, 3'd0, 3'd0, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL reset_state: got v=%b d=%h l=%b cnt=%0d hw=%0d e=%b f=%b, want all zero, empty=1",
               instr_out_valid, instr_out_data, instr_out_is_long, count, high_water, empty, full);
    end
    reset = 1'b1;
  endtask

  task automatic test_bypass();
    drive(1'b1, 32'hA5A5_0001, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle();
    checks++;
    if ({obs_stall, instr_out_valid, instr_out_data, instr_out_is_long, count}
        !== {1'b0, 1'b1, 32'hA5A5_0001, 1'b0, 3'd0}) begin
      failures++;
      $display("FAIL bypass: got stall=%b v=%b d=%h l=%b cnt=%0d, want 0 1 a5a50001 0 0",
               obs_stall, instr_out_valid, instr_out_data, instr_out_is_long, count);
    end
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle();
    checks++;
    if (instr_out_valid !== 1'b0) begin
      failures++;
      $display("FAIL bypass_pulse: got v=%b want 0", instr_out_valid);
    end
  endtask

  task automatic test_fill_full();
    logic [WIDTH-1:0] words [4];
    words[0] = 32'h11; words[1] = 32'h22; words[2] = 32'h33; words[3] = 32'h44;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, words[i], 1'b0, 1'b1, 1'b0, 1'b0);
      cycle();
      checks++;
      if ({obs_stall, count} !== {1'b0, CW'(i + 1)}) begin
        failures++;
        $display("FAIL fill[%0d]: got stall=%b cnt=%0d, want 0 %0d", i, obs_stall, count, i + 1);
      end
    end
    checks++;
    if ({full, empty, instr_out_valid} !== 3'b100) begin
      failures++;
      $display("FAIL full_flag: got full=%b empty=%b v=%b, want 1 0 0", full, empty, instr_out_valid);
    end
    drive(1'b1, 32'h55, 1'b0, 1'b1, 1'b0, 1'b0);
    cycle();
    checks++;
    if ({obs_stall, count, instr_out_valid} !== {1'b1, 3'd4, 1'b0}) begin
      failures++;
      $display("FAIL full_stall: got stall=%b cnt=%0d v=%b, want 1 4 0", obs_stall, count, instr_out_valid);
    end
  endtask

  task automatic test_full_push_pop();
    logic [WIDTH-1:0] drain [4];
    drain[0] = 32'h22; drain[1] = 32'h33; drain[2] = 32'h44; drain[3] = 32'h55;
    drive(1'b1, 32'h55, 1'b0, 1'b1, 1'b1, 1'b0);
    cycle();
    checks++;
    if ({obs_stall, instr_out_valid, instr_out_data, count} !== {1'b0, 1'b1, 32'h11, 3'd4}) begin
      failures++;
      $display("FAIL full_push_pop: got stall=%b v=%b d=%h cnt=%0d, want 0 1 00000011 4",
               obs_stall, instr_out_valid, instr_out_data, count);
    end
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cycle();
      checks++;
      if ({instr_out_valid, instr_out_data, count} !== {1'b1, drain[i], CW'(3 - i)}) begin
        failures++;
        $display("FAIL drain[%0d]: got v=%b d=%h cnt=%0d, want 1 %h %0d",
                 i, instr_out_valid, instr_out_data, count, drain[i], 3 - i);
      end
    end
    checks++;
    if ({high_water, empty} !== {3'd4, 1'b1}) begin
      failures++;
      $display("FAIL high_water_4: got hw=%0d empty=%b, want 4 1", high_water, empty);
    end
  endtask

  task automatic test_long();
    drive(1'b1, 32'h77, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle();
    checks++;
    if ({obs_stall, count, instr_out_valid} !== {1'b0, 3'd1, 1'b0}) begin
      failures++;
      $display("FAIL long_enqueue: got stall=%b cnt=%0d v=%b, want 0 1 0", obs_stall, count, instr_out_valid);
    end
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle();
    checks++;
    if ({instr_out_valid, instr_out_data, instr_out_is_long, count} !== {1'b1, 32'h77, 1'b1, 3'd0}) begin
      failures++;
      $display("FAIL long_dispatch: got v=%b d=%h l=%b cnt=%0d, want 1 00000077 1 0",
               instr_out_valid, instr_out_data, instr_out_is_long, count);
    end
  endtask

  task automatic test_flush();
    for (int i = 1; i <= 3; i++) begin
      drive(1'b1, WIDTH'(i), 1'b0, 1'b1, 1'b0, 1'b0);
      cycle();
    end
    checks++;
    if (count !== 3'd3) begin
      failures++;
      $display("FAIL flush_setup: got cnt=%0d want 3", count);
    end
    drive(1'b1, 32'h99, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle();
    checks++;
    if ({obs_stall, count, instr_out_valid, high_water} !== {1'b0, 3'd0, 1'b0, 3'd4}) begin
      failures++;
      $display("FAIL flush: got stall=%b cnt=%0d v=%b hw=%0d, want 0 0 0 4",
               obs_stall, count, instr_out_valid, high_water);
    end
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle();
    checks++;
    if ({instr_out_valid, count} !== {1'b0, 3'd0}) begin
      failures++;
      $display("FAIL flush_drop: got v=%b cnt=%0d, want 0 0", instr_out_valid, count);
    end
  endtask

  task automatic test_random();
    bit               pending = 1'b0;
    logic [WIDTH-1:0] p_data  = '0;
    logic             p_long  = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (!pending && $urandom_range(0, 3) != 0) begin
        pending = 1'b1;
        p_data  = $urandom;
        p_long  = ($urandom_range(0, 2) == 0);
      end
      reset = ($urandom_range(0, 99) != 0);
      drive(pending, p_data, p_long,
            (i % 200 < 100) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 24) == 0));
      cycle();
      checks++;
      if ({obs_stall, instr_out_valid, instr_out_is_long, instr_out_data, count, high_water, empty, full}
          !== {exp_stall, m_valid, m_long, m_data, CW'(exp_q.size()), m_hw,
               exp_q.size() == 0, exp_q.size() == DEPTH}) begin
        failures++;
        $display("FAIL random[%0d]: got stall=%b v=%b l=%b d=%h cnt=%0d hw=%0d e=%b f=%b, want stall=%b v=%b l=%b d=%h cnt=%0d hw=%0d",
                 i, obs_stall, instr_out_valid, instr_out_is_long, instr_out_data, count, high_water,
                 empty, full, exp_stall, m_valid, m_long, m_data, exp_q.size(), m_hw);
      end
      if (accepted || flush || !reset) pending = 1'b0;
    end
    reset = 1'b1;
  endtask

  task automatic test_reset_mid();
    drive(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b1);
    cycle();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, WIDTH'(32'hC0 + i), 1'b0, 1'b1, 1'b0, 1'b0);
      cycle();
    end
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle();
    checks++;
    if ({count, instr_out_valid, instr_out_data} !== {3'd2, 1'b1, 32'hC0}) begin
      failures++;
      $display("FAIL reset_mid_setup: got cnt=%0d v=%b d=%h, want 2 1 000000c0",
               count, instr_out_valid, instr_out_data);
    end
    reset = 1'b0;
    drive(1'b1, 32'hDD, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle();
    checks++;
    if ({instr_out_valid, instr_out_data, instr_out_is_long, count, high_water, empty}
        !== {1'b0, 32'h0, 1'b0, 3'd0, 3'd0, 1'b1}) begin
      failures++;
      $display("FAIL reset_mid: got v=%b d=%h l=%b cnt=%0d hw=%0d e=%b, want all zero, empty=1",
               instr_out_valid, instr_out_data, instr_out_is_long, count, high_water, empty);
    end
    reset = 1'b1;
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle();
  endtask

  initial begin
    m_valid = 1'b0; m_data = '0; m_long = 1'b0; m_hw = '0;
    exp_stall = 1'b0; accepted = 1'b0; obs_stall = 1'b0;
    reset = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    test_reset();
    test_bypass();
    test_fill_full();
    test_full_push_pop();
    test_long();
    test_flush();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
